// File: rtl/multi_tone_phase_gen.sv
// ============================================================================
// multi_tone_phase_gen : N-channel wrapped-phase accumulator bank, round-robin
//                        onto one AXI-Stream phase output for the CORDIC core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_tone_phase_gen #(
  parameter int            N_CH   = 2,
  parameter int            CH_W   = 1,
  parameter int            W      = 16,
  parameter logic [W-1:0]  PI_POS = 16'h6488
) (
  input  logic            cordic_clk,
  input  logic            RSTN,
  input  logic            enable,
  input  logic            sync_clr,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_inc,
  output logic            cfg_err,
  output logic            m_axis_phase_tvalid,
  input  logic            m_axis_phase_tready,
  output logic [W-1:0]    m_axis_phase_tdata,
  output logic [CH_W-1:0] m_axis_phase_tuser,
  output logic            m_axis_phase_tlast
);

  localparam logic signed [W+1:0] c_pi   = $signed({2'b00, PI_POS});
  localparam logic signed [W+1:0] c_npi  = -c_pi;
  localparam logic signed [W+1:0] c_2pi  = $signed({1'b0, PI_POS, 1'b0});
  localparam logic [CH_W-1:0]     c_last = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]       c_nch  = (CH_W + 1)'(N_CH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_ptr;
  logic              r_tvalid;
  logic [W-1:0]      r_tdata;
  logic [CH_W-1:0]   r_tuser;
  logic              r_tlast;
  logic              r_cfg_err;

  logic [W-1:0]      r_acc [N_CH];
  logic [W-1:0]      r_inc [N_CH];

  logic              w_hs;
  logic              w_cfg_ok;
  logic [CH_W-1:0]   w_nptr;
  logic [W-1:0]      w_acc_cur;
  logic [W-1:0]      w_inc_cur;
  logic [W-1:0]      w_acc_nxt;
  logic signed [W+1:0] w_sum;
  logic signed [W+1:0] w_wrap_full;
  logic signed [W+1:0] w_cfg_ext;
  logic [W-1:0]      w_wrapped;

  assign w_hs   = r_tvalid & m_axis_phase_tready;
  assign w_nptr = (r_ptr == c_last) ? '0 : r_ptr + CH_W'(1);

  always_comb begin
    w_acc_cur = '0;
    w_inc_cur = '0;
    w_acc_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_ptr == CH_W'(i)) begin
        w_acc_cur = r_acc[i];
        w_inc_cur = r_inc[i];
      end
      if (w_nptr == CH_W'(i)) begin
        w_acc_nxt = r_acc[i];
      end
    end
  end

  // Sum at extra precision so the fold back into [-pi, pi) is exact.
  assign w_sum = $signed({{2{w_acc_cur[W-1]}}, w_acc_cur})
               + $signed({{2{w_inc_cur[W-1]}}, w_inc_cur});

  always_comb begin
    if (w_sum >= c_pi) begin
      w_wrap_full = w_sum - c_2pi;
    end else if (w_sum < c_npi) begin
      w_wrap_full = w_sum + c_2pi;
    end else begin
      w_wrap_full = w_sum;
    end
  end

  assign w_wrapped = w_wrap_full[W-1:0];

  assign w_cfg_ext = $signed({{2{cfg_inc[W-1]}}, cfg_inc});
  assign w_cfg_ok  = ({1'b0, cfg_ch} < c_nch) && (w_cfg_ext < c_pi) && (w_cfg_ext > c_npi);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    always_ff @(posedge cordic_clk or negedge RSTN) begin
      if (!RSTN) begin
        r_acc[i] <= '0;
        r_inc[i] <= '0;
      end else begin
        if (sync_clr) begin
          r_acc[i] <= '0;
        end else if (w_hs && (r_ptr == CH_W'(i))) begin
          r_acc[i] <= w_wrapped;
        end
        if (cfg_we && !sync_clr && w_cfg_ok && (cfg_ch == CH_W'(i))) begin
          r_inc[i] <= cfg_inc;
        end
      end
    end
  end

  always_ff @(posedge cordic_clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tuser   <= '0;
      r_tlast   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we & ~sync_clr & ~w_cfg_ok;
      if (sync_clr) begin
        r_state  <= IDLE;
        r_ptr    <= '0;
        r_tvalid <= 1'b0;
        r_tdata  <= '0;
        r_tuser  <= '0;
        r_tlast  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (enable) begin
              r_state  <= RUN;
              r_tvalid <= 1'b1;
              r_tdata  <= w_acc_cur;
              r_tuser  <= r_ptr;
              r_tlast  <= (r_ptr == c_last);
            end
          end
          RUN: begin
            // A presented beat is only retired by a handshake, never by enable.
            if (w_hs) begin
              r_ptr <= w_nptr;
              if (enable) begin
                r_tdata <= w_acc_nxt;
                r_tuser <= w_nptr;
                r_tlast <= (w_nptr == c_last);
              end else begin
                r_state  <= IDLE;
                r_tvalid <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= IDLE;
            r_tvalid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_err             = r_cfg_err;
  assign m_axis_phase_tvalid = r_tvalid;
  assign m_axis_phase_tdata  = r_tdata;
  assign m_axis_phase_tuser  = r_tuser;
  assign m_axis_phase_tlast  = r_tlast;

endmodule

`default_nettype wire

// File: tb/tb_multi_tone_phase_gen.sv
// ============================================================================
// tb_multi_tone_phase_gen : directed bench for multi_tone_phase_gen.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_tone_phase_gen;

  logic        cordic_clk;
  logic        RSTN;
  logic        enable;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_inc;
  logic        cfg_err;
  logic        tvalid;
  logic        tready;
  logic [15:0] tdata;
  logic [1:0]  tuser;
  logic        tlast;

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed ch1 (+3000) and ch0 (-3000) sequences from zero.
  int pos_seq [10] = '{0, 3000, 6000, 9000, 12000, 15000, 18000, 21000, 24000, -24472};
  int neg_seq [10] = '{0, -3000, -6000, -9000, -12000, -15000, -18000, -21000, -24000, 24472};

  multi_tone_phase_gen #(
    .N_CH  (2),
    .CH_W  (2),
    .W     (16),
    .PI_POS(16'h6488)
  ) dut (
    .cordic_clk          (cordic_clk),
    .RSTN                (RSTN),
    .enable              (enable),
    .sync_clr            (sync_clr),
    .cfg_we              (cfg_we),
    .cfg_ch              (cfg_ch),
    .cfg_inc             (cfg_inc),
    .cfg_err             (cfg_err),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tready (tready),
    .m_axis_phase_tdata  (tdata),
    .m_axis_phase_tuser  (tuser),
    .m_axis_phase_tlast  (tlast)
  );

  initial cordic_clk = 1'b0;
  always #5 cordic_clk = ~cordic_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cordic_clk);
    #1;
  endtask

  task automatic beat(input int ch, input int d);
    logic [15:0] d16;
    logic signed [15:0] s16;
    d16 = d[15:0];
    s16 = $signed(tdata);
    check("tvalid", {31'h0, tvalid}, 32'd1);
    check("tuser",  {30'h0, tuser},  ch);
    check("tdata",  {16'h0, tdata},  {16'h0, d16});
    check("tlast",  {31'h0, tlast},  {31'h0, ch == 1});
    check("range",  {31'h0, (s16 >= -16'sd25736) && (s16 < 16'sd25736)}, 32'd1);
    step();
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] inc, input logic exp_err);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_inc = inc;
    step();
    cfg_we  = 1'b0;
    check("cfg_err", {31'h0, cfg_err}, {31'h0, exp_err});
  endtask

  initial begin
    RSTN = 1'b0; enable = 1'b0; sync_clr = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_inc = '0; tready = 1'b0;
    #12;
    check("rst_tvalid",  {31'h0, tvalid},  32'd0);
    check("rst_tdata",   {16'h0, tdata},   32'd0);
    check("rst_tuser",   {30'h0, tuser},   32'd0);
    check("rst_tlast",   {31'h0, tlast},   32'd0);
    check("rst_cfg_err", {31'h0, cfg_err}, 32'd0);
    RSTN = 1'b1;
    step();

    cfg_write(2'd0, 16'd200,  1'b0);
    cfg_write(2'd1, 16'd3000, 1'b0);

    // Basic sequence and positive wrap on ch1
    enable = 1'b1; tready = 1'b1;
    check("idle_tvalid", {31'h0, tvalid}, 32'd0);
    step();
    for (int k = 0; k < 10; k++) begin
      beat(0, 200 * k);
      beat(1, pos_seq[k]);
    end

    // Back-pressure: acc0=2000, acc1=-21472
    tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_tvalid", {31'h0, tvalid}, 32'd1);
      check("bp_tdata",  {16'h0, tdata},  32'd2000);
      check("bp_tuser",  {30'h0, tuser},  32'd0);
      check("bp_tlast",  {31'h0, tlast},  32'd0);
      step();
    end
    tready = 1'b1;
    beat(0, 2000);
    beat(1, -21472);
    beat(0, 2200);
    beat(1, -18472);

    // Rejected config writes while held
    tready = 1'b0;
    cfg_write(2'd0, 16'h6488, 1'b1);
    step();
    check("err_pulse0", {31'h0, cfg_err}, 32'd0);
    cfg_write(2'd2, 16'd5, 1'b1);
    step();
    check("err_pulse1", {31'h0, cfg_err}, 32'd0);
    cfg_write(2'd1, 16'h9B78, 1'b1);
    step();
    check("err_pulse2", {31'h0, cfg_err}, 32'd0);
    check("err_hold",   {16'h0, tdata}, 32'd2400);
    tready = 1'b1;
    beat(0, 2400);
    beat(1, -15472);
    beat(0, 2600);

    // sync_clr mid-run: presenting ch1 -12472
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("clr_tvalid", {31'h0, tvalid}, 32'd0);
    step();
    beat(0, 0);
    beat(1, 0);
    beat(0, 200);

    // Disable with back-pressure: beat ch1:3000 held until accepted
    enable = 1'b0; tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("dis_tvalid", {31'h0, tvalid}, 32'd1);
      check("dis_tdata",  {16'h0, tdata},  32'd3000);
      step();
    end
    tready = 1'b1;
    step();
    check("dis_drop", {31'h0, tvalid}, 32'd0);

    // Negative wrap on ch0 from a clean start
    cfg_write(2'd0, 16'hF448, 1'b0);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("idle2_tvalid", {31'h0, tvalid}, 32'd0);
    enable = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      beat(0, neg_seq[k]);
      beat(1, pos_seq[k]);
    end

    // Asynchronous reset mid-run
    #2;
    RSTN = 1'b0;
    #1;
    check("arst_tvalid", {31'h0, tvalid}, 32'd0);
    check("arst_tdata",  {16'h0, tdata},  32'd0);
    check("arst_tuser",  {30'h0, tuser},  32'd0);
    check("arst_tlast",  {31'h0, tlast},  32'd0);
    RSTN = 1'b1;
    step();
    beat(0, 0);
    beat(1, 0);
    beat(0, 0);
    beat(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_tone_phase_gen.md
Name: multi_tone_phase_gen

Overview:
- Parametrised N-channel phase-accumulator bank that generates wrapped radian phase streams for the shared CORDIC sin/cos core.
- Replaces the per-tone ad-hoc phase counters used when building multi-tone FIR stimulus.
- Channels are time-multiplexed round-robin onto one AXI-Stream-style phase output with back-pressure.
- Per-channel increments are run-time programmable, and negative increments are supported.

Parameters:
- N_CH, 2, number of tone channels (2..16).
- CH_W, 1, channel-index width; must satisfy 2**CH_W >= N_CH.
- W, 16, phase width; signed fixed point in CORDIC radian format (Q2.(W-3)).
- PI_POS, 16'h6488, +pi in phase format. -pi is defined as -PI_POS.

Ports:
- cordic_clk  in  1  clock.
- RSTN  in  1  reset; asynchronous assert, active-low.
- enable  in  1  run request; level-sensitive.
- sync_clr  in  1  synchronous clear of all accumulators and the channel pointer.
- cfg_we  in  1  increment write strobe.
- cfg_ch  in  CH_W  target channel for the write.
- cfg_inc  in  W  signed phase increment.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- m_axis_phase_tvalid  out  1  output data valid.
- m_axis_phase_tready  in  1  downstream ready.
- m_axis_phase_tdata  out  W  signed phase of the presented channel.
- m_axis_phase_tuser  out  CH_W  index of the presented channel.
- m_axis_phase_tlast  out  1  high when the presented channel is N_CH-1.

Behaviour:
- Reset (RSTN low, asynchronous):
  - All acc[i], all inc[i], and the channel pointer go to 0.
  - tvalid=0, tdata=0, tuser=0, tlast=0, cfg_err=0, state=IDLE.
- States:
  - IDLE: tvalid=0.
  - RUN: tvalid=1.
  - IDLE->RUN when enable=1. Latency is 1 cycle: the first beat presents channel 0 with acc[0].
  - RUN->IDLE when enable=0 and a handshake (tvalid & tready) occurs in that cycle.
  - With enable=0 and no handshake, the current beat is held until it is accepted; a beat is never withdrawn by enable.
- Handshake:
  - On tvalid & tready for channel c: acc[c] <= wrap(acc[c] + inc[c]).
  - The pointer advances to c+1, wrapping from N_CH-1 to 0.
  - The next beat presents the next channel's current acc. There are no bubbles, so throughput is one beat per cycle.
- Hold rule: while tvalid=1 and tready=0, tdata, tuser and tlast are stable and no accumulator changes.
- Wrap arithmetic:
  - Compute s = acc + inc at W+1 bits.
  - If s >= PI_POS, result = s - 2*PI_POS.
  - Else if s < -PI_POS, result = s + 2*PI_POS.
  - Otherwise result = s.
  - The result always lies in [-PI_POS, PI_POS).
- Config writes:
  - Accepted when cfg_ch < N_CH and |cfg_inc| < PI_POS.
  - An accepted write updates inc[cfg_ch] on the next edge and is used at that channel's next handshake.
  - A beat already presented is unaffected by the write.
  - A write and a handshake on the same channel in the same cycle: the handshake uses the old inc.
  - A rejected write leaves inc unchanged and pulses cfg_err high for exactly 1 cycle.
- sync_clr (priority over handshake and config write):
  - All acc go to 0 and the pointer goes to 0.
  - inc values are preserved.
  - tvalid drops to 0 for 1 cycle (the only permitted exception to the hold rule); the generator then restarts at channel 0 if enable=1.
- Reset mid-stream: immediate return to reset values. No state survives.

Test Plan:
- Basic sequence. Stimulus: N_CH=2, inc0=200, inc1=3000, enable=1, tready=1. Required output (tuser:tdata): 0:0, 1:0, 0:200, 1:3000, 0:400, 1:6000. tlast is high on every ch1 beat only.
- Positive wrap. Stimulus: inc1=3000, run 9 ch1 beats. Required: the 9th beat shows 24000 and the 10th shows -24472 (16'hA068). Every beat is within [-25736, 25736).
- Negative wrap. Stimulus: inc0=-3000. Required: beats 0, -3000, …, -24000, then 24472 (16'h5F98).
- Back-pressure. Stimulus: hold tready=0 for 5 cycles mid-stream. Required: tdata, tuser and tlast unchanged throughout; on release the sequence resumes with no skipped or repeated values.
- Config errors. Stimulus: write cfg_inc=16'h6488 to ch0, then cfg_ch=2 with N_CH=2. Required: cfg_err pulses 1 cycle for each write, and the stream is unchanged.
- Disable, sync_clr and reset.
  - enable=0 with tready=0: tvalid stays 1 until accepted, then goes to 0.
  - sync_clr mid-run: one tvalid=0 cycle, then 0:0, 1:0, 0:200.
  - RSTN pulse mid-run: all outputs go to 0 immediately and inc is cleared.
